// File: rtl/heaa_sub_pipe.sv
// rtl/heaa_sub_pipe.sv - two-stage approximate subtractor (OR-approximated low bits, exact upper sum)
// Valid/ready pipeline: S1 holds the approximate low bits and upper operand slices, S2 the full diff.
module heaa_sub_pipe #(
  parameter int W = 32,
  parameter int K = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   diff,
  output logic [15:0]  op_count
);

  localparam int HW = W - K;

  logic          s1_valid_q, s1_valid_d;
  logic [K-1:0]  s1_low_q, s1_low_d;
  logic          s1_c_q, s1_c_d;
  logic [HW-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HW-1:0] s1_nb_hi_q, s1_nb_hi_d;
  logic          s2_valid_q, s2_valid_d;
  logic [W:0]    diff_q, diff_d;
  logic [15:0]   op_count_q, op_count_d;

  logic          s1_adv;
  logic          s2_adv;
  logic [W-1:0]  nb;
  logic [HW:0]   hi_sum;

  // The +1 carry-in of a true two's-complement subtract is deliberately dropped.
  assign nb = ~b;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_low_d   = s1_low_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_nb_hi_d = s1_nb_hi_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_low_d[K-2:0] = a[K-2:0] | nb[K-2:0];
        s1_low_d[K-1]   = a[K-1] ^ nb[K-1];
        s1_c_d          = a[K-1] & nb[K-1];
        s1_a_hi_d       = a[W-1:K];
        s1_nb_hi_d      = nb[W-1:K];
      end
    end
  end

  assign hi_sum = {1'b0, s1_a_hi_q} + {1'b0, s1_nb_hi_q} + {{HW{1'b0}}, s1_c_q};

  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = {hi_sum, s1_low_q};
      end
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    if (s2_valid_q && out_ready && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_low_q   <= '0;
      s1_c_q     <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_nb_hi_q <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_low_q   <= s1_low_d;
      s1_c_q     <= s1_c_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_nb_hi_q <= s1_nb_hi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_heaa_sub_pipe.sv
// tb/tb_heaa_sub_pipe.sv - directed self-checking bench for heaa_sub_pipe
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_heaa_sub_pipe;

  localparam int W = 32;
  localparam int K = 10;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   diff;
  logic [15:0]  op_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];
  int         outc_q[$];

  heaa_sub_pipe #(.W(W), .K(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] ny;
    logic [W:0]   r;
    logic [W:0]   hi;
    logic         c;
    ny = ~y;
    r  = '0;
    for (int i = 0; i < K - 1; i++) r[i] = x[i] | ny[i];
    r[K-1] = x[K-1] ^ ny[K-1];
    c      = x[K-1] & ny[K-1];
    hi     = ({1'b0, x} >> K) + ({1'b0, ny} >> K) + {{W{1'b0}}, c};
    for (int i = K; i <= W; i++) r[i] = hi[i-K];
    return r;
  endfunction

  task automatic tick(output bit in_x);
    #1;
    in_x = in_valid && in_ready;
    if (in_x) exp_q.push_back(ref_diff(a, b));
    if (out_valid && out_ready) begin
      got_q.push_back(diff);
      outc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    outc_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL rst_diff got=%h want=0", diff); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rst_op_count got=%h want=0", op_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{32'h0000_1000, 32'h0000_0200, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] vb [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [W:0]   ve [4] = '{33'h1_0000_0FFE, 33'h1_0000_01FF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF};
    bit x;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; out_ready = 1'b1;
      tick(x);
      in_valid = 1'b0;
      checks++; if (x !== 1'b1) begin errors++; $display("FAIL vec%0d_accept got=%b want=1", i, x); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_lat1 out_valid got=%b want=0", i, out_valid); end
      tick(x);
      checks++;
      if (out_valid !== 1'b1 || diff !== ve[i]) begin
        errors++; $display("FAIL vec%0d_diff got=%b/%h want=1/%h", i, out_valid, diff, ve[i]);
      end
      tick(x);
    end
    clear_q();
  endtask

  task automatic test_stream();
    bit x;
    int n;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a = 32'h9E37_79B9 * (i + 1);
      b = 32'h7F4A_7C15 ^ (i << 20);
      tick(x);
    end
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 8 && n < 10) begin tick(x); n++; end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stream_count got=%0d want=8", got_q.size()); end
    if (got_q.size() == 8 && exp_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (outc_q[7] - outc_q[0] != 7) begin errors++; $display("FAIL stream_consecutive span=%0d want=7", outc_q[7] - outc_q[0]); end
    end
    checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL stream_op_count got=%0d want=8", op_count); end
    clear_q();
  endtask

  task automatic test_backpressure();
    bit         x;
    bit         saw_stall = 1'b0;
    bit         prev_hold = 1'b0;
    logic [W:0] prev_diff = '0;
    int         idx = 0;
    int         c = 0;
    do_reset();
    while (got_q.size() < 10 && c < 40) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (idx < 10);
      a = 32'h0123_4567 + idx * 32'h1111_0301;
      b = 32'h00F0_0F0F * (idx + 3);
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || diff !== prev_diff) begin
          errors++; $display("FAIL bp_hold c=%0d got=%b/%h want=1/%h", c, out_valid, diff, prev_diff);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_diff = diff;
      tick(x);
      if (x) idx++;
      c++;
    end
    in_valid = 1'b0;
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop got=%b want=1", saw_stall); end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL bp_count got=%0d want=10", got_q.size()); end
    if (got_q.size() == 10 && exp_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (op_count !== 16'd10) begin errors++; $display("FAIL bp_op_count got=%0d want=10", op_count); end
    clear_q();
  endtask

  task automatic test_reset_midstream();
    bit x;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 32'hA5A5_0000 + i; b = 32'h0000_5A5A * i;
      tick(x);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL mid_rst_op_count got=%0d want=0", op_count); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL mid_rst_diff got=%h want=0", diff); end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    in_valid = 1'b1; a = 32'h0000_1000; b = 32'h0000_0001;
    tick(x);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_lat1 out_valid got=%b want=0", out_valid); end
    tick(x);
    checks++;
    if (out_valid !== 1'b1 || diff !== 33'h1_0000_0FFE) begin
      errors++; $display("FAIL mid_first_op got=%b/%h want=1/100000ffe", out_valid, diff);
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stray_outputs got=%0d want=0", got_q.size()); end
    tick(x);
    clear_q();
  endtask

  task automatic test_saturation();
    bit x;
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h0000_1000; b = 32'h0000_0001;
    while (op_count !== 16'hFFFE && n < 70000) begin
      tick(x);
      n++;
      if (exp_q.size() > 16) begin exp_q.delete(); got_q.delete(); outc_q.delete(); end
    end
    checks++; if (op_count !== 16'hFFFE) begin errors++; $display("FAIL sat_reach got=%h want=fffe", op_count); end
    clear_q();
    tick(x);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(x);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL sat_xfers got=%0d want=3", got_q.size()); end
    checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value got=%h want=ffff", op_count); end
    in_valid = 1'b1;
    tick(x);
    tick(x);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(x);
    checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h want=ffff", op_count); end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stream();
    test_backpressure();
    test_reset_midstream();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
